// File: rtl/cpu6_memarb_if.sv
// Bundles the cpu6 fetch, load/store and RAM-side signals of the memory arbiter.
// The slave modport is the arbiter's view; the master modport is the core/RAM side.
interface cpu6_memarb_if #(
    parameter int XLEN = 32
);
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic            if_kill;
    logic            if_gnt;
    logic            if_rvalid;
    logic [XLEN-1:0] if_rdata;
    logic            ls_req;
    logic            ls_we;
    logic [XLEN-1:0] ls_addr;
    logic [XLEN-1:0] ls_wdata;
    logic            ls_gnt;
    logic            ls_rvalid;
    logic [XLEN-1:0] ls_rdata;
    logic            mem_en;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;
    logic            busy;

    modport slave (
        input  if_req, if_addr, if_kill, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, if_kill, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/cpu6_memarb.sv
// Arbitrates one single-port synchronous RAM between cpu6 fetch (IF) and load/store (LS).
// LS has priority, a starve counter forces IF through, and if_kill drops stale fetch data.
module cpu6_memarb #(
    parameter int XLEN        = 32,
    parameter int WAIT_CYCLES = 0,
    parameter int STARVE_MAX  = 4
) (
    input logic           clk,
    input logic           reset,
    cpu6_memarb_if.slave  bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_LS   = 2'd2;
    localparam logic [2:0] WAIT_INIT  = 3'(WAIT_CYCLES);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [1:0]      state_r,  state_nxt_s;
    logic [2:0]      wcnt_r,   wcnt_nxt_s;
    logic [3:0]      starve_r, starve_nxt_s;
    logic [1:0]      owner_r,  owner_nxt_s;
    logic            kill_r,   kill_nxt_s;
    logic            free_s, force_if_s, if_gnt_s, ls_gnt_s, gnt_any_s, gnt_rd_s;
    logic [1:0]      gnt_own_s;
    logic            mem_en_s, mem_we_s;
    logic [XLEN-1:0] mem_addr_s, mem_wdata_s;
    logic            resp_s, if_rvalid_s, ls_rvalid_s;

    assign free_s     = (state_r == ST_IDLE) || (state_r == ST_RESP);
    assign force_if_s = (starve_r == STARVE_LIM) && bus.if_req;

    // Grant selection; gated by reset so nothing leaks onto the RAM while reset is held
    always_comb begin
        if_gnt_s = 1'b0;
        ls_gnt_s = 1'b0;
        if (free_s && reset) begin
            if (bus.ls_req && !force_if_s) begin
                ls_gnt_s = 1'b1;
            end else if (bus.if_req) begin
                if_gnt_s = 1'b1;
            end else begin
                if_gnt_s = 1'b0;
            end
        end else begin
            ls_gnt_s = 1'b0;
        end
    end

    assign gnt_any_s = if_gnt_s || ls_gnt_s;
    assign gnt_rd_s  = if_gnt_s || (ls_gnt_s && !bus.ls_we);
    assign gnt_own_s = if_gnt_s ? OWN_IF : ((ls_gnt_s && !bus.ls_we) ? OWN_LS : OWN_NONE);

    // RAM command mux for the granted requester
    always_comb begin
        mem_en_s    = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = {XLEN{1'b0}};
        mem_wdata_s = {XLEN{1'b0}};
        if (ls_gnt_s) begin
            mem_en_s    = 1'b1;
            mem_we_s    = bus.ls_we;
            mem_addr_s  = bus.ls_addr;
            mem_wdata_s = bus.ls_wdata;
        end else if (if_gnt_s) begin
            mem_en_s    = 1'b1;
            mem_addr_s  = bus.if_addr;
        end else begin
            mem_en_s    = 1'b0;
        end
    end

    // Next-state logic: a write keeps owner NONE so its wait window ends in IDLE, not RESP
    always_comb begin
        state_nxt_s = state_r;
        wcnt_nxt_s  = wcnt_r;
        owner_nxt_s = owner_r;
        if (gnt_any_s) begin
            owner_nxt_s = gnt_own_s;
            if (WAIT_INIT == 3'd0) begin
                state_nxt_s = gnt_rd_s ? ST_RESP : ST_IDLE;
                wcnt_nxt_s  = 3'd0;
            end else begin
                state_nxt_s = ST_WAIT;
                wcnt_nxt_s  = WAIT_INIT;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    owner_nxt_s = OWN_NONE;
                end
                ST_WAIT: begin
                    if (wcnt_r <= 3'd1) begin
                        state_nxt_s = (owner_r == OWN_NONE) ? ST_IDLE : ST_RESP;
                        wcnt_nxt_s  = 3'd0;
                    end else begin
                        wcnt_nxt_s  = wcnt_r - 3'd1;
                    end
                end
                ST_RESP: begin
                    state_nxt_s = ST_IDLE;
                    owner_nxt_s = OWN_NONE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    wcnt_nxt_s  = 3'd0;
                    owner_nxt_s = OWN_NONE;
                end
            endcase
        end
    end

    // Starve counter: counts LS wins over a waiting fetch, saturating at the limit
    always_comb begin
        if (ls_gnt_s && bus.if_req) begin
            starve_nxt_s = (starve_r >= STARVE_LIM) ? STARVE_LIM : (starve_r + 4'd1);
        end else if (if_gnt_s || !bus.if_req) begin
            starve_nxt_s = 4'd0;
        end else begin
            starve_nxt_s = starve_r;
        end
    end

    // Kill flag: a kill on the granting edge wins over the RESP-cycle clear
    always_comb begin
        if (if_gnt_s && bus.if_kill) begin
            kill_nxt_s = 1'b1;
        end else if (state_r == ST_RESP) begin
            kill_nxt_s = 1'b0;
        end else if ((state_r == ST_WAIT) && (owner_r == OWN_IF) && bus.if_kill) begin
            kill_nxt_s = 1'b1;
        end else begin
            kill_nxt_s = kill_r;
        end
    end

    // Arbiter state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            wcnt_r   <= 3'd0;
            starve_r <= 4'd0;
            owner_r  <= OWN_NONE;
            kill_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            wcnt_r   <= wcnt_nxt_s;
            starve_r <= starve_nxt_s;
            owner_r  <= owner_nxt_s;
            kill_r   <= kill_nxt_s;
        end
    end

    assign resp_s      = (state_r == ST_RESP);
    assign if_rvalid_s = resp_s && (owner_r == OWN_IF) && !kill_r && !bus.if_kill;
    assign ls_rvalid_s = resp_s && (owner_r == OWN_LS);

    assign bus.if_gnt    = if_gnt_s;
    assign bus.ls_gnt    = ls_gnt_s;
    assign bus.if_rvalid = if_rvalid_s;
    assign bus.ls_rvalid = ls_rvalid_s;
    assign bus.if_rdata  = if_rvalid_s ? bus.mem_rdata : {XLEN{1'b0}};
    assign bus.ls_rdata  = ls_rvalid_s ? bus.mem_rdata : {XLEN{1'b0}};
    assign bus.mem_en    = mem_en_s;
    assign bus.mem_we    = mem_we_s;
    assign bus.mem_addr  = mem_addr_s;
    assign bus.mem_wdata = mem_wdata_s;
    assign bus.busy      = (state_r == ST_WAIT);
endmodule

// File: tb/tb_cpu6_memarb.sv
// Bench for cpu6_memarb: three instances (WAIT_CYCLES 0/1/2) share one stimulus stream,
// each with a small RAM model whose read data is a fixed function of the address.
module tb_cpu6_memarb;
    logic        clk;
    logic        reset;
    logic        if_req, if_kill, ls_req, ls_we;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        ls_req;
        logic        ls_we;
        logic [31:0] ls_addr;
        logic [31:0] ls_wdata;
        logic        e_if_gnt;
        logic        e_ls_gnt;
        logic        e_mem_we;
        logic [31:0] e_mem_addr;
        logic [31:0] e_mem_wdata;
    } vec_t;

    typedef struct {
        logic        is_ls;
        logic [31:0] data;
        int          due;
    } sb_t;

    vec_t vt[$];
    sb_t  sbq[$];

    cpu6_memarb_if #(.XLEN(32)) b0 ();
    cpu6_memarb_if #(.XLEN(32)) b1 ();
    cpu6_memarb_if #(.XLEN(32)) b2 ();

    cpu6_memarb #(.XLEN(32), .WAIT_CYCLES(0), .STARVE_MAX(4)) dut0 (.clk(clk), .reset(reset), .bus(b0));
    cpu6_memarb #(.XLEN(32), .WAIT_CYCLES(1), .STARVE_MAX(4)) dut1 (.clk(clk), .reset(reset), .bus(b1));
    cpu6_memarb #(.XLEN(32), .WAIT_CYCLES(2), .STARVE_MAX(4)) dut2 (.clk(clk), .reset(reset), .bus(b2));

    function automatic logic [31:0] ramf(input logic [31:0] a);
        return (a >> 2) - 32'h36;
    endfunction

    assign b0.if_req = if_req;   assign b1.if_req = if_req;   assign b2.if_req = if_req;
    assign b0.if_addr = if_addr; assign b1.if_addr = if_addr; assign b2.if_addr = if_addr;
    assign b0.if_kill = if_kill; assign b1.if_kill = if_kill; assign b2.if_kill = if_kill;
    assign b0.ls_req = ls_req;   assign b1.ls_req = ls_req;   assign b2.ls_req = ls_req;
    assign b0.ls_we = ls_we;     assign b1.ls_we = ls_we;     assign b2.ls_we = ls_we;
    assign b0.ls_addr = ls_addr; assign b1.ls_addr = ls_addr; assign b2.ls_addr = ls_addr;
    assign b0.ls_wdata = ls_wdata; assign b1.ls_wdata = ls_wdata; assign b2.ls_wdata = ls_wdata;

    // RAM models: the address sampled at an edge comes back WAIT_CYCLES+1 cycles after the command
    logic [31:0] h0;
    logic [31:0] h1 [0:1];
    logic [31:0] h2 [0:2];
    always @(posedge clk) begin
        h0    <= b0.mem_addr;
        h1[0] <= b1.mem_addr;
        h1[1] <= h1[0];
        h2[0] <= b2.mem_addr;
        h2[1] <= h2[0];
        h2[2] <= h2[1];
    end
    assign b0.mem_rdata = ramf(h0);
    assign b1.mem_rdata = ramf(h1[1]);
    assign b2.mem_rdata = ramf(h2[2]);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic ik, input logic lr,
                         input logic lw, input logic [31:0] la, input logic [31:0] ld);
        if_req = ir; if_addr = ia; if_kill = ik;
        ls_req = lr; ls_we = lw; ls_addr = la; ls_wdata = ld;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (n) next_cycle();
    endtask

    function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic lr, input logic lw,
                                input logic [31:0] la, input logic [31:0] ld,
                                input logic eig, input logic elg);
        vec_t v;
        v.if_req = ir; v.if_addr = ia; v.ls_req = lr; v.ls_we = lw; v.ls_addr = la; v.ls_wdata = ld;
        v.e_if_gnt    = eig;
        v.e_ls_gnt    = elg;
        v.e_mem_we    = elg & lw;
        v.e_mem_addr  = elg ? la : (eig ? ia : 32'h0);
        v.e_mem_wdata = elg ? ld : 32'h0;
        return v;
    endfunction

    initial begin
        sb_t e;
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        // requests while reset is held must not reach the outputs
        drive(1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0);
        #1;
        chk1("rst_if_gnt", b0.if_gnt, 1'b0);
        chk1("rst_ls_gnt", b0.ls_gnt, 1'b0);
        chk1("rst_mem_en", b0.mem_en, 1'b0);
        chk32("rst_mem_addr", b0.mem_addr, 32'h0);
        chk1("rst_busy", b0.busy, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        chk1("post_rst_if_gnt", b0.if_gnt, 1'b0);
        chk1("post_rst_mem_en", b0.mem_en, 1'b0);
        chk1("post_rst_if_rvalid", b0.if_rvalid, 1'b0);
        chk1("post_rst_ls_rvalid", b0.ls_rvalid, 1'b0);
        next_cycle();

        // WAIT_CYCLES=0 table: back-to-back fetches, store vs fetch, starvation pattern
        vt.push_back(mk(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0));
        vt.push_back(mk(1'b1, 32'h100, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0));
        vt.push_back(mk(1'b1, 32'h104, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0));
        vt.push_back(mk(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0));
        vt.push_back(mk(1'b1, 32'h108, 1'b1, 1'b1, 32'h300, 32'h0000DEAD, 1'b0, 1'b1));
        vt.push_back(mk(1'b1, 32'h108, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0));
        vt.push_back(mk(1'b0, 32'h0,   1'b1, 1'b0, 32'h200, 32'h0,        1'b0, 1'b1));
        for (int k = 0; k < 10; k++) begin
            vt.push_back(mk(1'b1, 32'h10C, 1'b1, 1'b0, 32'h204, 32'h0, (k % 5) == 4, (k % 5) != 4));
        end
        vt.push_back(mk(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0));
        vt.push_back(mk(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0));

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].if_req, vt[i].if_addr, 1'b0, vt[i].ls_req, vt[i].ls_we, vt[i].ls_addr, vt[i].ls_wdata);
            @(negedge clk);
            chk1("tbl_if_gnt", b0.if_gnt, vt[i].e_if_gnt);
            chk1("tbl_ls_gnt", b0.ls_gnt, vt[i].e_ls_gnt);
            chk1("tbl_mem_en", b0.mem_en, vt[i].e_if_gnt | vt[i].e_ls_gnt);
            chk1("tbl_mem_we", b0.mem_we, vt[i].e_mem_we);
            chk32("tbl_mem_addr", b0.mem_addr, vt[i].e_mem_addr);
            chk32("tbl_mem_wdata", b0.mem_wdata, vt[i].e_mem_wdata);
            chk1("tbl_busy", b0.busy, 1'b0);
            if (sbq.size() > 0 && sbq[0].due == i) begin
                e = sbq.pop_front();
                chk1("sb_ls_rvalid", b0.ls_rvalid, e.is_ls);
                chk1("sb_if_rvalid", b0.if_rvalid, !e.is_ls);
                chk32("sb_rdata", e.is_ls ? b0.ls_rdata : b0.if_rdata, e.data);
            end else begin
                chk1("sb_ls_rvalid_idle", b0.ls_rvalid, 1'b0);
                chk1("sb_if_rvalid_idle", b0.if_rvalid, 1'b0);
            end
            if ((vt[i].e_if_gnt || vt[i].e_ls_gnt) && !vt[i].e_mem_we) begin
                e.is_ls = vt[i].e_ls_gnt;
                e.data  = ramf(vt[i].e_mem_addr);
                e.due   = i + 1;
                sbq.push_back(e);
            end
            next_cycle();
        end
        chk32("sb_drained", 32'(sbq.size()), 32'h0);

        // kill in the grant cycle, WAIT_CYCLES=0
        drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk1("killg_if_gnt", b0.if_gnt, 1'b1);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk1("killg_if_rvalid", b0.if_rvalid, 1'b0);
        idle(5);

        // WAIT_CYCLES=2 load: busy two cycles, fetch blocked, data at T+3
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0);
        @(negedge clk);
        chk1("w2_ls_gnt", b2.ls_gnt, 1'b1);
        chk32("w2_mem_addr", b2.mem_addr, 32'h200);
        next_cycle();
        drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk1("w2_busy", b2.busy, 1'b1);
            chk1("w2_if_gnt_blocked", b2.if_gnt, 1'b0);
            chk1("w2_mem_en_blocked", b2.mem_en, 1'b0);
            chk1("w2_ls_rvalid_early", b2.ls_rvalid, 1'b0);
            next_cycle();
        end
        @(negedge clk);
        chk1("w2_ls_rvalid", b2.ls_rvalid, 1'b1);
        chk32("w2_ls_rdata", b2.ls_rdata, 32'h4A);
        chk1("w2_busy_resp", b2.busy, 1'b0);
        chk1("w2_if_gnt_resp", b2.if_gnt, 1'b1);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk1("w2_if_busy", b2.busy, 1'b1);
        idle(5);

        // WAIT_CYCLES=1: kill in the wait cycle, LS read granted in RESP returns normally
        drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk1("w1_if_gnt", b1.if_gnt, 1'b1);
        next_cycle();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk1("w1_busy", b1.busy, 1'b1);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h204, 32'h0);
        @(negedge clk);
        chk1("w1_killed_rvalid", b1.if_rvalid, 1'b0);
        chk1("w1_ls_gnt_resp", b1.ls_gnt, 1'b1);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk1("w1_ls_busy", b1.busy, 1'b1);
        chk1("w1_ls_rvalid_early", b1.ls_rvalid, 1'b0);
        next_cycle();
        @(negedge clk);
        chk1("w1_ls_rvalid", b1.ls_rvalid, 1'b1);
        chk32("w1_ls_rdata", b1.ls_rdata, 32'h4B);
        chk1("w1_if_rvalid_after", b1.if_rvalid, 1'b0);
        idle(5);

        // reset during WAIT of a fetch on the WAIT_CYCLES=2 instance
        drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk1("rmid_if_gnt", b2.if_gnt, 1'b1);
        next_cycle();
        @(negedge clk);
        chk1("rmid_busy", b2.busy, 1'b1);
        reset = 1'b0;
        #1;
        chk1("rmid_busy_cleared", b2.busy, 1'b0);
        chk1("rmid_if_gnt_gated", b2.if_gnt, 1'b0);
        chk1("rmid_mem_en_gated", b2.mem_en, 1'b0);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        chk1("rmid_rel_if_rvalid", b2.if_rvalid, 1'b0);
        chk1("rmid_rel_busy", b2.busy, 1'b0);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h208, 32'h0);
        @(negedge clk);
        chk1("rmid_first_ls_gnt", b2.ls_gnt, 1'b1);
        chk1("rmid_no_if_rvalid0", b2.if_rvalid, 1'b0);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk1("rmid_no_if_rvalid", b2.if_rvalid, 1'b0);
            next_cycle();
        end
        @(negedge clk);
        chk1("rmid_ls_rvalid", b2.ls_rvalid, 1'b1);
        chk32("rmid_ls_rdata", b2.ls_rdata, 32'h4C);
        chk1("rmid_if_rvalid_end", b2.if_rvalid, 1'b0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
